// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 sizes, schedule FSM states and sigma helpers.
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;
  localparam int BLK_WORDS = 16;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_sched_expand.sv
// sha256_sched_expand: combinational next-word adder for the schedule window.
module sha256_sched_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] nw
);
  assign nw = sig1(w14) + w9 + sig0(w1) + w0;
endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: loads a 16-word block and streams W0..W63 to the compression core.
module sha256_msg_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ROUNDS = 64,
  parameter int BLK_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_dv_in,
  output logic                  in_ready_out,
  input  logic                  hold_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [6:0]            count_out,
  output logic                  dv_out,
  output logic                  done_out
);
  import sha256_pkg::*;
  state_t state;
  logic [3:0] lcnt;
  logic [5:0] t;
  logic [DATA_WIDTH-1:0] win [BLK_WORDS];
  logic [DATA_WIDTH-1:0] nw;
  logic load_shift, run_shift;
  sha256_sched_expand expand (
    .w0  (win[0]),
    .w1  (win[1]),
    .w9  (win[9]),
    .w14 (win[14]),
    .nw  (nw)
  );
  assign in_ready_out = state == LOAD;
  assign load_shift = in_ready_out && data_dv_in;
  assign run_shift = state == RUN && !hold_in;
  // The window shifts uniformly in LOAD and RUN; only the word entering the top differs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lcnt <= '0;
      t <= '0;
      data_out <= '0;
      count_out <= '0;
      dv_out <= 1'b0;
      done_out <= 1'b0;
      for (int i = 0; i < BLK_WORDS; i++) win[i] <= '0;
    end else begin
      dv_out <= run_shift;
      done_out <= state == DONE;
      if (load_shift || run_shift) begin
        for (int i = 0; i < BLK_WORDS - 1; i++) win[i] <= win[i+1];
        win[BLK_WORDS-1] <= load_shift ? data_in : nw;
      end
      if (load_shift) lcnt <= lcnt + 1'b1;
      if (run_shift) begin
        data_out <= win[0];
        count_out <= {1'b0, t};
        t <= t + 1'b1;
      end
      case (state)
        IDLE: if (start_in) begin
          state <= LOAD;
          lcnt <= '0;
        end
        LOAD: if (load_shift && lcnt == 4'(BLK_WORDS - 1)) begin
          state <= RUN;
          t <= '0;
        end
        RUN: if (run_shift && t == 6'(ROUNDS - 1)) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: randomized scoreboard bench against a direct SHA-256 schedule model.
module tb_sha256_msg_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_in = 1'b0;
  logic data_dv_in = 1'b0;
  logic hold_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [6:0] count_out;
  logic in_ready_out, dv_out, done_out;
  int checks = 0;
  int errors = 0;
  logic [31:0] blk [16];
  logic [31:0] wref [64];
  logic [38:0] sb [$];
  logic [38:0] e;
  bit pend = 1'b0;
  bit kat_on = 1'b0;
  always #5 clk = ~clk;
  sha256_msg_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .data_in      (data_in),
    .data_dv_in   (data_dv_in),
    .in_ready_out (in_ready_out),
    .hold_in      (hold_in),
    .data_out     (data_out),
    .count_out    (count_out),
    .dv_out       (dv_out),
    .done_out     (done_out)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction
  task automatic build_ref();
    for (int t = 0; t < 64; t++) begin
      wref[t] = t < 16 ? blk[t] : s1(wref[t-2]) + wref[t-7] + s0(wref[t-15]) + wref[t-16];
      sb.push_back({7'(t), wref[t]});
    end
  endtask
  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask
  always @(negedge clk) begin
    if (rst) pend = 1'b0;
    else begin
      if (done_out || pend) chk("done_out", 32'(done_out), 32'(pend));
      pend = dv_out && count_out == 7'd63;
      if (dv_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected dv_out: count %0d data %h, nothing expected", count_out, data_out);
        end else begin
          e = sb.pop_front();
          chk("count_out", 32'(count_out), 32'(e[38:32]));
          chk("data_out", data_out, e[31:0]);
          if (kat_on)
            case (count_out)
              7'd0: chk("kat W0", data_out, 32'h61626380);
              7'd15: chk("kat W15", data_out, 32'h00000018);
              7'd16: chk("kat W16", data_out, 32'h61626380);
              7'd17: chk("kat W17", data_out, 32'h000f0000);
              7'd18: chk("kat W18", data_out, 32'h7da86405);
              default: ;
            endcase
        end
      end
    end
  end
  task automatic load(input int gap, input bit junk, input bit noise);
    int i, cyc;
    bit v;
    build_ref();
    @(posedge clk);
    #1 start_in = 1'b1;
    data_dv_in = junk;
    data_in = 32'hdeadbeef;
    @(posedge clk);
    #1 start_in = 1'b0;
    data_dv_in = 1'b0;
    chk("in_ready entering load", 32'(in_ready_out), 32'd1);
    i = 0;
    cyc = 0;
    while (i < 16) begin
      v = gap == 0 ? 1'b1 : gap == 1 ? cyc % 2 == 1 : $urandom_range(0, 2) != 0;
      data_dv_in = v;
      data_in = v ? blk[i] : $urandom;
      if (noise) begin
        start_in = 1'($urandom_range(0, 1));
        hold_in = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      if (v) i++;
      cyc++;
      chk("in_ready", 32'(in_ready_out), 32'(i < 16));
    end
    data_dv_in = 1'b0;
    start_in = 1'b0;
    hold_in = 1'b0;
  endtask
  task automatic run(input int mode, input int rst_at, input bit noise);
    int n, hc;
    bit h;
    n = 0;
    hc = 0;
    while (n < 64) begin
      if (n == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst dv_out", 32'(dv_out), 32'd0);
        chk("rst done_out", 32'(done_out), 32'd0);
        chk("rst in_ready", 32'(in_ready_out), 32'd0);
        chk("rst count_out", 32'(count_out), 32'd0);
        chk("rst data_out", data_out, 32'd0);
        sb.delete();
        rst = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1 chk("dv after rst", 32'(dv_out), 32'd0);
        end
        return;
      end
      h = mode == 1 ? (n == 20 && hc < 3) || (n == 63 && hc < 1) :
          mode == 2 ? $urandom_range(0, 3) == 0 : 1'b0;
      hc = h ? hc + 1 : 0;
      hold_in = h;
      if (noise) start_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (h) begin
        chk("dv during hold", 32'(dv_out), 32'd0);
        if (n > 0) chk("data held", data_out, wref[n-1]);
      end else begin
        chk("dv_out run", 32'(dv_out), 32'd1);
        n++;
      end
    end
    hold_in = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    start_in = 1'b0;
    @(posedge clk);
    #1 hold_in = 1'b0;
    chk("dv after W63", 32'(dv_out), 32'd0);
    @(posedge clk);
    #1 chk("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset dv_out", 32'(dv_out), 32'd0);
    chk("reset done_out", 32'(done_out), 32'd0);
    chk("reset in_ready", 32'(in_ready_out), 32'd0);
    chk("reset count_out", 32'(count_out), 32'd0);
    chk("reset data_out", data_out, 32'd0);
    rst = 1'b0;
    set_abc();
    kat_on = 1'b1;
    load(0, 1'b0, 1'b0);
    run(0, -1, 1'b0);
    kat_on = 1'b0;
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    load(0, 1'b0, 1'b0);
    run(0, -1, 1'b0);
    set_abc();
    load(1, 1'b0, 1'b0);
    run(0, -1, 1'b0);
    load(0, 1'b0, 1'b0);
    run(1, -1, 1'b0);
    load(0, 1'b0, 1'b0);
    run(0, 30, 1'b0);
    kat_on = 1'b1;
    load(0, 1'b1, 1'b0);
    run(0, -1, 1'b0);
    kat_on = 1'b0;
    load(0, 1'b1, 1'b1);
    run(0, -1, 1'b1);
    repeat (4) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      load(2, 1'($urandom_range(0, 1)), 1'b1);
      run(2, -1, 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
